lif_stdp_array: RTL and testbench

- Parametrised successor to the two-neuron LIF/STDP core: N_IN input spike channels fully connected to N_OUT leaky integrate-and-fire neurons.
- Each synapse weight adapts online by pair-based STDP using decaying pre- and post-synaptic traces.
- Time advances only on a `step` strobe.
- Sits below the Tiny Tapeout top wrapper, which maps ui_in/uo_out/uio onto the ports below.

---
 rtl/lif_stdp_array.sv | 205 ++++++++++++++++++++
 tb/tb_lif_stdp_array.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/lif_stdp_array.sv
// lif_stdp_array
//   N_IN presynaptic spike channels fully connected to N_OUT leaky
//   integrate-and-fire neurons. Every synapse weight adapts online by
//   pair-based STDP driven by decaying pre/post traces. Time only advances
//   on the `step` strobe. A host port can write and read any weight.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   step       one-cycle strobe, advance one time step
//   in_spike   [N_IN]   presynaptic spikes (sampled on step)
//   learn_en   enables STDP weight updates
//   wr_en      host weight write strobe
//   wr_addr    [AW]     weight index = j*N_IN + i
//   wr_data    [W_W]    weight value to write
//   rd_addr    [AW]     weight read index
//   rd_data    [W_W]    registered weight read, 1-cycle latency
//   out_spike  [N_OUT]  one-cycle postsynaptic spike pulses
//   spike_count [N_OUT*8] saturating per-neuron fire counters
//              (present only when LIF_STDP_SPIKE_COUNT_EN is defined)
//
// Optional feature macro: LIF_STDP_SPIKE_COUNT_EN

module lif_stdp_array #(
    parameter int N_IN       = 2,
    parameter int N_OUT      = 2,
    parameter int V_W        = 8,
    parameter int W_W        = 6,
    parameter int W_INIT     = 32,
    parameter int THRESH     = 96,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int TRACE_W    = 3,
    localparam int N_SYN     = N_IN * N_OUT,
    localparam int AW        = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic [N_IN-1:0]  in_spike,
    input  logic             learn_en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W_W-1:0]   wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [W_W-1:0]   rd_data,
    output logic [N_OUT-1:0] out_spike
`ifdef LIF_STDP_SPIKE_COUNT_EN
    ,
    output logic [N_OUT*8-1:0] spike_count
`endif
);

    // Accumulator wide enough for v plus every weight at full scale.
    localparam int SW    = V_W + W_W + $clog2(N_IN);
    localparam int RW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int V_MAX = (1 << V_W) - 1;

    logic [W_W-1:0]   w_arr [N_SYN];   // current (pre-update) weights
    logic [N_IN-1:0]  pre_live;        // pre_trace[i] > 0, pre-step
    logic [N_OUT-1:0] post_live;       // post_trace[j] > 0, pre-step
    logic [N_OUT-1:0] fire_vec;        // this step's fire decision
    logic [W_W-1:0]   rd_data_q;

    genvar gi, gj;

    // Presynaptic traces
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_pre
            logic [TRACE_W-1:0] pre_q, pre_d;

            always_comb begin
                pre_d = pre_q;
                if (step) begin
                    if (in_spike[gi])
                        pre_d = '1;
                    else if (pre_q != '0)
                        pre_d = pre_q - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pre_q <= '0;
                else        pre_q <= pre_d;
            end

            assign pre_live[gi] = (pre_q != '0);
        end
    endgenerate

    // Neurons: leak, integrate, fire, refractory, post trace
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_neuron
            logic [SW-1:0]      acc;
            logic [V_W-1:0]     v_sat;
            logic [V_W-1:0]     v_q, v_d;
            logic [RW-1:0]      refrac_q, refrac_d;
            logic [TRACE_W-1:0] post_q, post_d;
            logic               spike_q;
            logic               fire;

            always_comb begin
                acc = SW'(v_q - (v_q >> LEAK_SHIFT));
                for (int i = 0; i < N_IN; i++) begin
                    if (in_spike[i])
                        acc = acc + SW'(w_arr[gi*N_IN + i]);
                end
                v_sat = (acc > SW'(V_MAX)) ? '1 : acc[V_W-1:0];
                fire  = step && (refrac_q == '0) && (v_sat >= V_W'(THRESH));

                v_d      = v_q;
                refrac_d = refrac_q;
                post_d   = post_q;
                if (step) begin
                    if (refrac_q != '0) begin
                        refrac_d = refrac_q - 1'b1;
                        v_d      = '0;
                    end else if (fire) begin
                        v_d      = '0;
                        refrac_d = RW'(REFRAC);
                    end else begin
                        v_d      = v_sat;
                    end
                    if (fire)
                        post_d = '1;
                    else if (post_q != '0)
                        post_d = post_q - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q      <= '0;
                    refrac_q <= '0;
                    post_q   <= '0;
                    spike_q  <= 1'b0;
                end else begin
                    v_q      <= v_d;
                    refrac_q <= refrac_d;
                    post_q   <= post_d;
                    spike_q  <= fire;   // high only the cycle after a firing step
                end
            end

            assign fire_vec[gi]  = fire;
            assign post_live[gi] = (post_q != '0);
            assign out_spike[gi] = spike_q;

`ifdef LIF_STDP_SPIKE_COUNT_EN
            logic [7:0] cnt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_q <= '0;
                else if (fire && (cnt_q != 8'hFF))
                    cnt_q <= cnt_q + 8'd1;
            end
            assign spike_count[gi*8 +: 8] = cnt_q;
`endif
        end
    endgenerate

    // Synapses: STDP with host-write priority
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_row
            for (gj = 0; gj < N_IN; gj++) begin : g_syn
                localparam int K = gi*N_IN + gj;
                logic [W_W-1:0] w_q, w_d;
                logic           pot, dep;

                always_comb begin
                    pot = learn_en && fire_vec[gi] && pre_live[gj];
                    dep = learn_en && step && in_spike[gj] && post_live[gi];
                    w_d = w_q;
                    if (wr_en && (wr_addr == AW'(K)))
                        w_d = wr_data;
                    // Coincident pot and dep cancel to a net delta of 0.
                    else if (pot && !dep && (w_q != '1))
                        w_d = w_q + 1'b1;
                    else if (dep && !pot && (w_q != '0))
                        w_d = w_q - 1'b1;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) w_q <= W_W'(W_INIT);
                    else        w_q <= w_d;
                end

                assign w_arr[K] = w_q;
            end
        end
    endgenerate

    // Host read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_q <= '0;
        else if (int'(rd_addr) < N_SYN)
            rd_data_q <= w_arr[rd_addr];
        else
            rd_data_q <= '0;
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_lif_stdp_array.sv
// Directed testbench for lif_stdp_array with default parameters.
module tb_lif_stdp_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step;
    logic [1:0] in_spike;
    logic       learn_en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [5:0] wr_data;
    logic [1:0] rd_addr;
    logic [5:0] rd_data;
    logic [1:0] out_spike;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lif_stdp_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step),
        .in_spike  (in_spike),
        .learn_en  (learn_en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_spike (out_spike)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One clock cycle of stimulus, entered and left on a falling edge.
    task automatic cyc(input logic st, input logic [1:0] spk, input logic we,
                       input logic [1:0] wa, input logic [5:0] wd);
        step = st; in_spike = spk; wr_en = we; wr_addr = wa; wr_data = wd;
        @(negedge clk);
        step = 1'b0; in_spike = 2'b00; wr_en = 1'b0;
    endtask

    task automatic stp(input logic [1:0] spk);
        cyc(1'b1, spk, 1'b0, 2'd0, 6'd0);
    endtask

    task automatic rd_w(input logic [1:0] a, input logic [5:0] exp, input string tag);
        rd_addr = a;
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; step = 1'b0; in_spike = 2'b00; wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] int_exp [10];
        logic [1:0] leak_spk [7];
        logic [1:0] leak_exp [7];
        int_exp  = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
        leak_spk = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        leak_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};

        rst_n = 1'b0; step = 1'b0; in_spike = 2'b00; learn_en = 1'b0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 6'd0; rd_addr = 2'd0;
        #1;
        check("reset out_spike", out_spike, 0);
        check("reset rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Integration: v0 = 32, 60, 85, 107 -> fire; 2 refractory steps; refire at step 10
        for (int i = 0; i < 10; i++) begin
            stp(2'b01);
            check($sformatf("integrate step%0d", i + 1), out_spike, int_exp[i]);
        end
        @(negedge clk);
        check("pulse cleared when idle", out_spike, 0);

        // Leak: 64 -> 56 -> 49 -> 43, then 70, 94 (below 96), 115 fires
        do_reset;
        for (int i = 0; i < 7; i++) begin
            stp(leak_spk[i]);
            check($sformatf("leak step%0d", i + 1), out_spike, leak_exp[i]);
        end
        rd_w(2'd0, 6'd32, "leak w0 unchanged");

        // Potentiation then depression
        do_reset;
        learn_en = 1'b1;
        stp(2'b01); check("pot step1", out_spike, 0);
        stp(2'b11); check("pot step2", out_spike, 0);
        stp(2'b11); check("pot step3 fire", out_spike, 3);
        rd_w(2'd0, 6'd33, "pot w0");
        rd_w(2'd3, 6'd33, "pot w3");
        stp(2'b01); check("dep step", out_spike, 0);
        rd_w(2'd0, 6'd32, "dep w0");
        rd_w(2'd1, 6'd33, "dep w1 untouched");
        rd_w(2'd2, 6'd32, "dep w2");

        // Saturation at both ends, plus write-to-read latency
        do_reset;
        learn_en = 1'b1;
        rd_addr = 2'd0;
        cyc(1'b0, 2'b00, 1'b1, 2'd0, 6'd63);
        check("rd old value in write cycle", rd_data, 32);
        @(negedge clk);
        check("rd new value 1 cycle later", rd_data, 63);
        cyc(1'b0, 2'b00, 1'b1, 2'd1, 6'd0);
        rd_w(2'd1, 6'd0, "write w1=0");
        stp(2'b01); check("sat step A", out_spike, 0);
        stp(2'b01); check("sat step B fire n0", out_spike, 1);
        stp(2'b10); check("sat step C", out_spike, 0);
        rd_w(2'd0, 6'd63, "sat w0 stays 63");
        rd_w(2'd1, 6'd0, "sat w1 stays 0");
        rd_w(2'd2, 6'd32, "sat w2");
        rd_w(2'd3, 6'd32, "sat w3");

        // Host write collides with a potentiating step
        do_reset;
        learn_en = 1'b1;
        stp(2'b01);
        stp(2'b11);
        cyc(1'b1, 2'b11, 1'b1, 2'd0, 6'd10);
        check("collision fire", out_spike, 3);
        rd_w(2'd0, 6'd10, "collision w0 write wins");
        rd_w(2'd1, 6'd33, "collision w1 potentiated");
        rd_w(2'd2, 6'd33, "collision w2 potentiated");

        // Asynchronous reset with a pending spike and nonzero state
        learn_en = 1'b0;
        stp(2'b00);
        stp(2'b00);
        stp(2'b11); check("pre-reset step1", out_spike, 0);
        stp(2'b11); check("pre-reset fire n1", out_spike, 2);
        #1 rst_n = 1'b0;
        #1;
        check("async reset out_spike", out_spike, 0);
        check("async reset rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_w(2'd0, 6'd32, "post-reset w0");
        rd_w(2'd1, 6'd32, "post-reset w1");
        rd_w(2'd2, 6'd32, "post-reset w2");
        rd_w(2'd3, 6'd32, "post-reset w3");
        for (int i = 0; i < 4; i++) begin
            stp(2'b01);
            check($sformatf("post-reset integrate step%0d", i + 1), out_spike, int_exp[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
